ibuffer_warp_fifo: RTL and testbench
====================================

// Module: ibuffer_warp_fifo
// PURPOSE
//  Per-warp decoded-instruction buffer, parametrised successor of the fixed 4-entry warp buffer.
//  Sits between the dual decode unit (ID) and the issue unit (IU) / operand collector (OC).
//  Provides credit-based fetch requests to IF, ordered dual enqueue, and 1-per-cycle issue on IU grant.
//  Also handles SIMT drop flushes with in-flight discard, and exit tracking toward the RAU.
// PARAMETERS
//  NUM_ENTRIES  4   FIFO depth; power of 2, >=2
//  DATA_W       76  packed decoded bundle width (instr, src/dst, ALUop, imme, flags)
//  MAX_INFLIGHT 3   max outstanding IF fetches tracked (counter width = $clog2(MAX_INFLIGHT+1))
// PORTS
//  clk              in   1       clock
//  rst              in   1       asynchronous reset, active-low
//  start_IB         in   1       pulse: warp (re)assigned; EXITED -> RUN
//  valid_IF_IB      in   1       IF issued one fetch for this warp this cycle
//  req_IB_IF        out  1       buffer can absorb one more fetch (2 instrs)
//  valid_Q1_ID_IB   in   1       decode slot 1 valid
//  data_Q1_ID_IB    in   DATA_W  decode slot 1 bundle
//  exit_Q1_ID_IB    in   1       slot 1 is EXIT
//  valid_Q2_ID_IB   in   1       decode slot 2 valid
//  data_Q2_ID_IB    in   DATA_W  decode slot 2 bundle
//  exit_Q2_ID_IB    in   1       slot 2 is EXIT
//  drop_SIMT_IB     in   1       branch redirect: flush buffer and in-flight decodes
//  req_IB_IU        out  1       head entry ready for issue
//  grt_IU_IB        in   1       IU grant; dequeues head this cycle
//  valid_IB_OC      out  1       registered issue strobe to OC
//  data_IB_OC       out  DATA_W  registered issued bundle
//  exit_IB_RAU      out  1       1-cycle pulse: EXIT instruction issued
//  count_IB         out  $clog2(NUM_ENTRIES+1) current occupancy
// BEHAVIOUR
//  Reset: FIFO empty, ptrs/inflight/discard=0, state RUN; all outputs 0 (req_IB_IF from comb after reset).
//  FSM: RUN --(EXIT issued on grant)--> EXITED --(start_IB)--> RUN. EXITED: req_IB_IF=0, req_IB_IU=0,
//    all decode beats dropped, FIFO cleared on entry. start_IB in RUN ignored.
//  Decode beat = valid_Q1|valid_Q2; each beat retires one in-flight fetch (inflight-1, saturating at 0).
//  Enqueue: Q1 then Q2 in program order; Q2-only beat writes one entry. Entries store bundle+exit bit.
//  Credit: req_IB_IF = RUN & (count + 2*(inflight+1) <= NUM_ENTRIES) & inflight<MAX_INFLIGHT.
//    valid_IF_IB without req is a protocol error (assertion); overflow is impossible by construction.
//  Issue: req_IB_IU = RUN & !empty. Grant with req: head popped same cycle; next cycle
//    valid_IB_OC=1, data_IB_OC=head bundle, exit_IB_RAU=exit bit. Grant without req ignored.
//  Grant->OC latency 1 cycle; throughput 1 instr/cycle. Enqueue and dequeue in same cycle allowed;
//    count = count + enq_n - deq_n; full FIFO + pop + 2 pushes not reachable (credit reserves slots).
//  Drop: FIFO cleared next cycle, discard = inflight (+1 if valid_IF_IB same cycle), inflight=0.
//    Beats arriving while discard>0 are dropped and decrement discard. Drop beats enqueue/grant
//    in same cycle: no push, no pop, valid_IB_OC=0 next cycle. Drop in EXITED: no effect.
//  Pointers wrap modulo NUM_ENTRIES; full/empty from count, not ptr equality.
//  Async reset mid-operation: all state cleared immediately; in-flight ID beats after reset are
//    enqueued normally (upstream is reset concurrently).
// CONFIGURATION
//  IB_BYPASS_EN defined: when FIFO empty, RUN, no discard and valid_Q1 (or Q2-only) arrives, req_IB_IU
//    asserts same cycle; grant issues that instruction directly (valid_IB_OC next cycle), the other
//    slot (if any) is enqueued. Saves one cycle decode->issue.
//  Not defined: decoded instructions always enqueued first; earliest req_IB_IU is cycle after beat.
// TESTING
//  1 Reset, 2 fetches, beats Q1+Q2 x2 (A,B,C,D), grt held -> OC sees A,B,C,D on 4 consecutive cycles.
//  2 NUM_ENTRIES=4, count=2, inflight=1 -> req_IB_IF=0; after one grant -> still 0; after 2 -> 1.
//  3 2 fetches in flight, drop_SIMT_IB -> count=0 next cycle; next 2 beats dropped, 3rd beat enqueued.
//  4 Grant on EXIT entry -> exit_IB_RAU=1 one cycle, state EXITED, req_IB_IF=req_IB_IU=0 until start_IB.
//  5 drop and grant same cycle with 3 entries -> valid_IB_OC=0 next cycle, count=0.
//  6 IB_BYPASS_EN: empty FIFO, Q1=A, grt same cycle -> valid_IB_OC=1 data=A next cycle, count stays 0.

Source files
------------

// File: rtl/ibuffer_warp_fifo.sv
// ibuffer_warp_fifo: per-warp decoded-instruction buffer between dual decode (ID) and issue (IU/OC).
// Optional macro IB_BYPASS_EN lets a beat reaching an empty buffer be issued in the same cycle.
module ibuffer_warp_fifo #(
    parameter int NUM_ENTRIES  = 4,
    parameter int DATA_W       = 76,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_IB,
    input  logic                             valid_IF_IB,
    output logic                             req_IB_IF,
    input  logic                             valid_Q1_ID_IB,
    input  logic [DATA_W-1:0]                data_Q1_ID_IB,
    input  logic                             exit_Q1_ID_IB,
    input  logic                             valid_Q2_ID_IB,
    input  logic [DATA_W-1:0]                data_Q2_ID_IB,
    input  logic                             exit_Q2_ID_IB,
    input  logic                             drop_SIMT_IB,
    output logic                             req_IB_IU,
    input  logic                             grt_IU_IB,
    output logic                             valid_IB_OC,
    output logic [DATA_W-1:0]                data_IB_OC,
    output logic                             exit_IB_RAU,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] count_IB
);
    localparam int CW = $clog2(NUM_ENTRIES + 1);
    localparam int PW = $clog2(NUM_ENTRIES);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int EW = DATA_W + 1;  // bundle with its exit flag on top

    typedef enum logic {ST_RUN, ST_EXITED} state_t;

    state_t        state_q;
    logic [EW-1:0] mem [NUM_ENTRIES];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] inflight_q, discard_q;

    logic          run, beat, fetch, do_drop, accept, bypass, pop, byp_take, pop_mem, exit_pop;
    logic          wr0_en, wr1_en;
    logic [1:0]    enq_n;
    logic [EW-1:0] in_first, in_second, wr0_data, head;

    // NOTE: every signal gets an unconditional assignment here, so no latch can be inferred.
    always_comb begin
        run       = (state_q == ST_RUN);
        beat      = valid_Q1_ID_IB | valid_Q2_ID_IB;
        req_IB_IF = run
                    && (int'(count_q) + 2 * (int'(inflight_q) + 1) <= NUM_ENTRIES)
                    && (int'(inflight_q) < MAX_INFLIGHT);
        fetch     = valid_IF_IB & req_IB_IF;
        do_drop   = run & drop_SIMT_IB;
        accept    = run & (discard_q == '0) & ~do_drop;
        in_first  = valid_Q1_ID_IB ? {exit_Q1_ID_IB, data_Q1_ID_IB} : {exit_Q2_ID_IB, data_Q2_ID_IB};
        in_second = {exit_Q2_ID_IB, data_Q2_ID_IB};
`ifdef IB_BYPASS_EN
        bypass    = run & (discard_q == '0) & beat & (count_q == '0);
`else
        bypass    = 1'b0;
`endif
        req_IB_IU = run & ((count_q != '0) | bypass);
        pop       = req_IB_IU & grt_IU_IB & ~do_drop;
        // With an empty buffer a pop can only be the bypassed first decode slot.
        byp_take  = pop & (count_q == '0);
        pop_mem   = pop & ~byp_take;
        head      = (count_q == '0) ? in_first : mem[rd_ptr_q];
        exit_pop  = pop & head[DATA_W];
        enq_n     = accept ? (2'(valid_Q1_ID_IB) + 2'(valid_Q2_ID_IB) - 2'(byp_take)) : 2'd0;
        wr0_en    = (enq_n != 2'd0);
        wr1_en    = (enq_n == 2'd2);
        wr0_data  = byp_take ? in_second : in_first;
        count_d   = count_q + CW'(enq_n) - CW'(pop_mem);
    end

    // NOTE: the storage array has no reset; count_q alone decides which words are live.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr_ptr_q] <= wr0_data;
        if (wr1_en) mem[wr_ptr_q + PW'(1)] <= in_second;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            inflight_q  <= '0;
            discard_q   <= '0;
            valid_IB_OC <= 1'b0;
            data_IB_OC  <= '0;
            exit_IB_RAU <= 1'b0;
        end else begin
            valid_IB_OC <= pop;
            exit_IB_RAU <= exit_pop;
            if (pop) data_IB_OC <= head[DATA_W-1:0];

            // A drop turns every outstanding fetch into a beat that must be thrown away.
            if (do_drop) begin
                discard_q  <= inflight_q + IW'(fetch);
                inflight_q <= '0;
            end else begin
                if (beat && discard_q != '0) discard_q <= discard_q - IW'(1);
                inflight_q <= inflight_q + IW'(fetch)
                              - IW'(beat && discard_q == '0 && inflight_q != '0);
            end

            if (do_drop || exit_pop) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_q + PW'(pop_mem);
                wr_ptr_q <= wr_ptr_q + PW'(enq_n);
                count_q  <= count_d;
            end

            if (exit_pop)               state_q <= ST_EXITED;
            else if (!run && start_IB)  state_q <= ST_RUN;
        end
    end

    assign count_IB = count_q;

    // Upstream may only issue a fetch while credit is offered.
    fetch_needs_credit: assert property (@(posedge clk) disable iff (!rst) valid_IF_IB |-> req_IB_IF);

endmodule

// File: tb/tb_ibuffer_warp_fifo.sv
// Bench for ibuffer_warp_fifo: directed scenarios, then randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_ibuffer_warp_fifo;
    localparam int NUM_ENTRIES  = 4;
    localparam int DATA_W       = 76;
    localparam int MAX_INFLIGHT = 3;
`ifdef IB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    typedef logic [DATA_W:0] entry_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_IB, valid_IF_IB, req_IB_IF;
    logic              valid_Q1_ID_IB, exit_Q1_ID_IB, valid_Q2_ID_IB, exit_Q2_ID_IB;
    logic [DATA_W-1:0] data_Q1_ID_IB, data_Q2_ID_IB, data_IB_OC;
    logic              drop_SIMT_IB, req_IB_IU, grt_IU_IB, valid_IB_OC, exit_IB_RAU;
    logic [2:0]        count_IB;

    ibuffer_warp_fifo #(
        .NUM_ENTRIES(NUM_ENTRIES), .DATA_W(DATA_W), .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clk(clk), .rst(rst), .start_IB(start_IB),
        .valid_IF_IB(valid_IF_IB), .req_IB_IF(req_IB_IF),
        .valid_Q1_ID_IB(valid_Q1_ID_IB), .data_Q1_ID_IB(data_Q1_ID_IB), .exit_Q1_ID_IB(exit_Q1_ID_IB),
        .valid_Q2_ID_IB(valid_Q2_ID_IB), .data_Q2_ID_IB(data_Q2_ID_IB), .exit_Q2_ID_IB(exit_Q2_ID_IB),
        .drop_SIMT_IB(drop_SIMT_IB), .req_IB_IU(req_IB_IU), .grt_IU_IB(grt_IU_IB),
        .valid_IB_OC(valid_IB_OC), .data_IB_OC(data_IB_OC), .exit_IB_RAU(exit_IB_RAU),
        .count_IB(count_IB)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: buffer contents as a queue plus fetch bookkeeping.
    entry_t            q[$];
    int                m_inflight, m_discard;
    bit                m_run, exp_valid, exp_exit;
    logic [DATA_W-1:0] exp_data;

    task automatic check(input string tag, input entry_t got, input entry_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_inflight = 0;
        m_discard  = 0;
        m_run      = 1'b1;
        exp_valid  = 1'b0;
        exp_exit   = 1'b0;
    endtask

    task automatic drive_idle();
        start_IB = 0; valid_IF_IB = 0; drop_SIMT_IB = 0; grt_IU_IB = 0;
        valid_Q1_ID_IB = 0; exit_Q1_ID_IB = 0; data_Q1_ID_IB = '0;
        valid_Q2_ID_IB = 0; exit_Q2_ID_IB = 0; data_Q2_ID_IB = '0;
    endtask

    // One cycle: called just after a falling edge, drives inputs, advances model and checks outputs.
    task automatic step(input bit f, input bit v1, input bit x1, input bit v2, input bit x2,
                        input bit dr, input bit g, input bit st);
        logic [95:0]       r1, r2;
        logic [DATA_W-1:0] d1, d2;
        entry_t            head;
        bit                beat, req_if, fetch, byp, req_iu, do_drop, pop, accept;
        if (m_inflight + m_discard == 0) begin
            v1 = 0;
            v2 = 0;
        end
        beat   = v1 | v2;
        req_if = m_run && (q.size() + 2 * (m_inflight + 1) <= NUM_ENTRIES) && (m_inflight < MAX_INFLIGHT);
        fetch  = f && req_if;
        r1 = {$urandom(), $urandom(), $urandom()};
        r2 = {$urandom(), $urandom(), $urandom()};
        d1 = r1[DATA_W-1:0];
        d2 = r2[DATA_W-1:0];
        valid_IF_IB    = fetch;
        valid_Q1_ID_IB = v1; data_Q1_ID_IB = d1; exit_Q1_ID_IB = x1 & v1;
        valid_Q2_ID_IB = v2; data_Q2_ID_IB = d2; exit_Q2_ID_IB = x2 & v2;
        drop_SIMT_IB   = dr; grt_IU_IB = g; start_IB = st;
        byp    = BYPASS && m_run && q.size() == 0 && m_discard == 0 && beat;
        req_iu = m_run && (q.size() != 0 || byp);
        #1;
        check("req_IB_IU", entry_t'(req_IB_IU), entry_t'(req_iu));
        check("req_IB_IF", entry_t'(req_IB_IF), entry_t'(req_if));

        do_drop = m_run && dr;
        pop     = req_iu && g && !do_drop;
        accept  = m_run && m_discard == 0 && !do_drop;
        if (accept && v1) q.push_back({x1, d1});
        if (accept && v2) q.push_back({x2, d2});
        head = '0;
        if (pop) head = q.pop_front();
        exp_valid = pop;
        exp_exit  = pop && head[DATA_W];
        exp_data  = head[DATA_W-1:0];
        if (do_drop) begin
            m_discard  = m_inflight + (fetch ? 1 : 0);
            m_inflight = 0;
        end else begin
            if (beat && m_discard > 0) m_discard--;
            else if (beat && m_inflight > 0) m_inflight--;
            if (fetch) m_inflight++;
        end
        if (exp_exit) begin
            m_run = 1'b0;
            q.delete();
        end else if (!m_run && st) begin
            m_run = 1'b1;
        end
        if (do_drop) q.delete();

        @(posedge clk);
        @(negedge clk);
        check("valid_IB_OC", entry_t'(valid_IB_OC), entry_t'(exp_valid));
        check("exit_IB_RAU", entry_t'(exit_IB_RAU), entry_t'(exp_exit));
        if (exp_valid) check("data_IB_OC", entry_t'(data_IB_OC), entry_t'(exp_data));
        check("count_IB", entry_t'(count_IB), entry_t'(q.size()));
    endtask

    initial begin
        drive_idle();
        repeat (3) @(negedge clk);
        check("rst_count", entry_t'(count_IB), entry_t'(0));
        check("rst_valid", entry_t'(valid_IB_OC), entry_t'(0));
        check("rst_exit", entry_t'(exit_IB_RAU), entry_t'(0));
        check("rst_data", entry_t'(data_IB_OC), entry_t'(0));
        check("rst_req_iu", entry_t'(req_IB_IU), entry_t'(0));
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("post_rst_req_if", entry_t'(req_IB_IF), entry_t'(1));

        // Two fetches, two full beats, grant held: A,B,C,D on consecutive cycles.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Credit withheld at count=2, inflight=1 until two entries drain.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        check("credit_c2_i1", entry_t'(req_IB_IF), entry_t'(0));
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("credit_c1_i1", entry_t'(req_IB_IF), entry_t'(0));
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("credit_c0_i1", entry_t'(req_IB_IF), entry_t'(1));
        step(0, 1, 0, 1, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 1, 0);

        // Drop with two fetches outstanding: their beats vanish, the next fetch's beat lands.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        check("drop_discarded", entry_t'(count_IB), entry_t'(0));
        step(0, 1, 0, 1, 0, 0, 0, 0);
        check("drop_third_beat", entry_t'(count_IB), entry_t'(2));
        repeat (2) step(0, 0, 0, 0, 0, 0, 1, 0);

        // EXIT issue: pulse, EXITED with no requests, drop ignored, start_IB resumes.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("exit_pulse", entry_t'(exit_IB_RAU), entry_t'(1));
        step(0, 0, 0, 0, 0, 1, 1, 0);
        check("exited_req_if", entry_t'(req_IB_IF), entry_t'(0));
        check("exited_req_iu", entry_t'(req_IB_IU), entry_t'(0));
        check("exit_one_cycle", entry_t'(exit_IB_RAU), entry_t'(0));
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("restart_req_if", entry_t'(req_IB_IF), entry_t'(1));

        // Drop and grant together with three entries buffered.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        check("drop_grant_valid", entry_t'(valid_IB_OC), entry_t'(0));
        check("drop_grant_count", entry_t'(count_IB), entry_t'(0));

`ifdef IB_BYPASS_EN
        // Empty buffer, Q1 with same-cycle grant issues directly.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1, 0);
        check("bypass_valid", entry_t'(valid_IB_OC), entry_t'(1));
        check("bypass_count", entry_t'(count_IB), entry_t'(0));
`endif

        for (int c = 0; c < 3000; c++) begin
            bit f, v1, v2, x1, x2, dr, g, st;
            int kind;
            f    = ($urandom_range(0, 1) == 1);
            kind = $urandom_range(0, 4);
            v1   = (kind == 2) || (kind == 3);
            v2   = (kind == 2) || (kind == 4);
            x1   = ($urandom_range(0, 31) == 0);
            x2   = ($urandom_range(0, 31) == 0);
            dr   = (m_discard == 0) && !(v1 || v2) && ($urandom_range(0, 39) == 0);
            g    = ($urandom_range(0, 9) < 7);
            st   = m_run ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 4) == 0);
            if (c == 1500) begin
                #2 rst = 1'b0;
                drive_idle();
                #1;
                check("async_rst_count", entry_t'(count_IB), entry_t'(0));
                check("async_rst_valid", entry_t'(valid_IB_OC), entry_t'(0));
                model_reset();
                @(negedge clk);
                rst = 1'b1;
            end
            step(f, v1, x1, v2, x2, dr, g, st);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
